// File: rtl/shift_pkg.sv
// Shared definitions for the shift datapath: operand width, shift-amount
// width and the 2-bit mode encoding used by requesters and the shifter.
package shift_pkg;

  localparam int XLEN    = 64;
  localparam int SHAMT_W = 6;

  localparam logic [1:0] SH_SLL  = 2'b00;
  localparam logic [1:0] SH_SRL  = 2'b01;
  localparam logic [1:0] SH_SRA  = 2'b10;
  localparam logic [1:0] SH_PASS = 2'b11;

endpackage

// File: rtl/shift_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans req starting at the internal pointer and grants
// the first requester found. The pointer moves past the winner only when the
// caller reports that the grant was actually used (advance).
// Ports:
//   clk, rst_n - clock, async active-low reset (pointer resets to 0)
//   req        - per-requester request
//   advance    - grant consumed this cycle
//   gnt        - one-hot grant (zero when no request)
//   gnt_idx    - index of the granted requester
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = PW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/shifter.sv
// Purely combinational 64-bit shifter shared by all requesters.
// Ports:
//   din   - operand
//   shamt - unsigned shift amount 0..63
//   mode  - SH_SLL / SH_SRL / SH_SRA / SH_PASS (pass ignores shamt)
//   dout  - result
module shifter
  import shift_pkg::*;
(
  input  logic [XLEN-1:0]    din,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic [XLEN-1:0]    dout
);

  always_comb begin
    dout = din;
    case (mode)
      SH_SLL:  dout = din << shamt;
      SH_SRL:  dout = din >> shamt;
      SH_SRA:  dout = XLEN'($signed(din) >>> shamt);
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one combinational shifter between NREQ requesters using round-robin
// arbitration, with a single registered response slot tagged by requester id.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   req_valid  - per-requester valid
//   req_ready  - per-requester accept (one-hot or zero, zero during reset)
//   req_din    - operands, requester i at [64*i +: 64]
//   req_shamt  - shift amounts, requester i at [6*i +: 6]
//   req_mode   - modes, requester i at [2*i +: 2]
//   rsp_valid  - response slot full
//   rsp_ready  - downstream accepts response
//   rsp_data   - shifted result
//   rsp_id     - requester that produced rsp_data
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*XLEN-1:0]    req_din,
  input  logic [NREQ*SHAMT_W-1:0] req_shamt,
  input  logic [NREQ*2-1:0]       req_mode,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [XLEN-1:0]         rsp_data,
  output logic [IDW-1:0]          rsp_id
);

  logic [NREQ-1:0]    gnt;
  logic [IDW-1:0]     gnt_idx;
  logic               can_accept;
  logic               fire;
  logic [XLEN-1:0]    sh_din, sh_dout;
  logic [SHAMT_W-1:0] sh_shamt;
  logic [1:0]         sh_mode;

  logic               rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]    rsp_data_q, rsp_data_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;

  // A full slot being drained this cycle may take a new result.
  assign can_accept = !rsp_valid_q || rsp_ready;
  // rst_n gates ready so nothing is accepted while reset is held.
  assign req_ready  = (can_accept && rst_n) ? gnt : '0;
  assign fire       = |req_ready;

  rr_arbiter #(.N(NREQ), .PW(IDW)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (fire),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    sh_din   = '0;
    sh_shamt = '0;
    sh_mode  = SH_PASS;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sh_din   = req_din[XLEN*i +: XLEN];
        sh_shamt = req_shamt[SHAMT_W*i +: SHAMT_W];
        sh_mode  = req_mode[2*i +: 2];
      end
    end
  end

  shifter u_shifter (
    .din   (sh_din),
    .shamt (sh_shamt),
    .mode  (sh_mode),
    .dout  (sh_dout)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    if (fire) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = sh_dout;
      rsp_id_d    = gnt_idx;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*64-1:0] req_din;
  logic [N*6-1:0] req_shamt;
  logic [N*2-1:0] req_mode;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [63:0]    rsp_data;
  logic [0:0]     rsp_id;

  int n_cmp = 0;
  int n_err = 0;

  // reference state: round-robin pointer plus the response slot
  int          m_ptr;
  bit          m_valid;
  logic [63:0] m_data;
  int          m_id;
  logic [N-1:0] last_acc;

  always #5 clk = ~clk;

  shift_arbiter #(.NREQ(N), .IDW(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din   (req_din),
    .req_shamt (req_shamt),
    .req_mode  (req_mode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int s, input int m);
    case (m)
      0: return d << s;
      1: return d >> s;
      2: return d[63] ? ~((~d) >> s) : (d >> s);
      default: return d;
    endcase
  endfunction

  task automatic set_req(input int i, input bit v, input logic [63:0] d, input int s, input int m);
    req_valid[i]        = v;
    req_din[64*i +: 64] = d;
    req_shamt[6*i +: 6] = 6'(s);
    req_mode[2*i +: 2]  = 2'(m);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = '0; m_id = 0; last_acc = '0;
  endtask

  // Called just after a falling edge with inputs applied; ends on the next falling edge.
  task automatic step();
    int w;
    int idx;
    logic [N-1:0] er;
    logic [63:0] res;
    #1;
    w = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (w < 0 && req_valid[idx]) w = idx;
    end
    er = '0;
    res = '0;
    if (w >= 0 && (!m_valid || rsp_ready)) begin
      er[w] = 1'b1;
      res = ref_shift(req_din[64*w +: 64], int'(req_shamt[6*w +: 6]), int'(req_mode[2*w +: 2]));
    end
    check("req_ready", 64'(req_ready), 64'(er));
    @(posedge clk);
    if (er != '0) begin
      m_valid = 1; m_data = res; m_id = w; m_ptr = (w + 1) % N;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    last_acc = er;
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    check("rsp_data", rsp_data, m_data);
    check("rsp_id", 64'(rsp_id), 64'(m_id));
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] din5;
    logic [63:0] d;
    rst_n = 1'b0;
    req_valid = '0; req_din = '0; req_shamt = '0; req_mode = '0;
    rsp_ready = 1'b1;
    model_reset();
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset
    repeat (5) step();
    check("t1_data", rsp_data, 64'd0);

    // 2: req0 SLL 3 of 1
    set_req(0, 1, 64'h1, 3, 0);
    step();
    check("t2_data", rsp_data, 64'h8);
    set_req(0, 0, 0, 0, 0);
    step();

    // 3: both valid, alternate grants
    set_req(0, 1, 64'h8000_0000_0000_0000, 1, 1);
    set_req(1, 1, 64'h8000_0000_0000_0000, 1, 2);
    for (int c = 0; c < 4; c++) begin
      step();
      check("t3_id", 64'(rsp_id), 64'(c % 2 == 0 ? 1 : 0));
      check("t3_data", rsp_data, (c % 2 == 0) ? 64'hC000_0000_0000_0000 : 64'h4000_0000_0000_0000);
    end

    // 4: backpressure with both valid
    rsp_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("t4_hold_id", 64'(rsp_id), 64'd0);
    end
    rsp_ready = 1'b1;
    step();
    check("t4_release_id", 64'(rsp_id), 64'd1);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    step();

    // 5: pass mode ignores shamt; shamt=0 returns din in every mode
    din5 = 64'h1234_5678_9ABC_DEF0;
    set_req(0, 1, din5, 7, 3);
    step();
    check("t5_pass", rsp_data, din5);
    for (int m = 0; m < 4; m++) begin
      d = {$urandom, $urandom} | 64'h8000_0000_0000_0001;
      set_req(0, 1, d, 0, m);
      step();
      check("t5_shamt0", rsp_data, d);
    end
    set_req(0, 0, 0, 0, 0);
    step();

    // 6: reset while full; req0 wins first afterwards
    set_req(0, 1, 64'h55, 1, 0);
    step();
    set_req(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_valid", 64'(rsp_valid), 64'd0);
    check("t6_ready", 64'(req_ready), 64'd0);
    check("t6_data", rsp_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1, 64'h10, 4, 1);
    set_req(1, 1, 64'h20, 4, 1);
    step();
    check("t6_first_id", 64'(rsp_id), 64'd0);
    check("t6_first_data", rsp_data, 64'h1);

    // random traffic; a requester not yet accepted keeps its operands
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !last_acc[i])) begin
          set_req(i, ($urandom_range(0, 99) < 65), {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 63),
                  $urandom_range(0, 3));
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
